// File: rtl/decode_pipe.sv
// Decode stage: register file with write-through bypass, destination select,
// load-use stall detection and the ID/EX pipeline register.
module decode_pipe #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned LINK_REG = 31
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_rs,
  input  logic [ADDR_W-1:0] i_rt,
  input  logic [ADDR_W-1:0] i_rd,
  input  logic [1:0]        i_c_regdst,
  input  logic              i_c_regwrite,
  input  logic              i_c_memread,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_mfc0,
  input  logic [DATA_W-1:0] i_cop0_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic [ADDR_W-1:0] o_wraddr,
  output logic              o_regwrite,
  output logic              o_memread,
  output logic              o_stall
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LinkAddr = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] rf_q [NumRegs];
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W-1:0] dest;
  logic              wb_live;

  logic              valid_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [ADDR_W-1:0] wraddr_q;
  logic              regwrite_q;
  logic              memread_q;

  assign wd      = i_mfc0 ? i_cop0_data : i_wb_data;
  assign wb_live = i_wb_we && (i_wb_addr != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_live) begin
      rf_q[i_wb_addr] <= wd;
    end
  end

  // r0 is hard zero; a same-cycle write-back to a read address is forwarded.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (i_rs != '0) begin
      rs_data = (wb_live && (i_wb_addr == i_rs)) ? wd : rf_q[i_rs];
    end
    if (i_rt != '0) begin
      rt_data = (wb_live && (i_wb_addr == i_rt)) ? wd : rf_q[i_rt];
    end
  end

  always_comb begin
    dest = i_rt;
    case (i_c_regdst)
      2'd1:    dest = i_rd;
      2'd2:    dest = LinkAddr;
      default: dest = i_rt;
    endcase
  end

  assign o_valid    = valid_q;
  assign o_op1      = op1_q;
  assign o_op2      = op2_q;
  assign o_wraddr   = wraddr_q;
  assign o_regwrite = regwrite_q & valid_q;
  assign o_memread  = memread_q & valid_q;

  assign o_stall = i_valid && o_valid && o_memread && (o_wraddr != '0) &&
                   ((o_wraddr == i_rs) || (o_wraddr == i_rt)) && !i_flush;

  // Flush and bubble both kill the slot; operand/address fields simply hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q    <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      wraddr_q   <= '0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else if (i_flush || o_stall) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= i_valid;
      op1_q      <= rs_data;
      op2_q      <= rt_data;
      wraddr_q   <= dest;
      regwrite_q <= i_c_regwrite;
      memread_q  <= i_c_memread;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed bench for decode_pipe: register file, bypass, load-use stall,
// flush, destination select and asynchronous reset.
module tb_decode_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [4:0]  i_rs, i_rt, i_rd;
  logic [1:0]  i_c_regdst;
  logic        i_c_regwrite, i_c_memread, i_flush;
  logic        i_wb_we;
  logic [4:0]  i_wb_addr;
  logic [31:0] i_wb_data;
  logic        i_mfc0;
  logic [31:0] i_cop0_data;
  logic        o_valid;
  logic [31:0] o_op1, o_op2;
  logic [4:0]  o_wraddr;
  logic        o_regwrite, o_memread, o_stall;

  int vectors     = 0;
  int miscompares = 0;

  decode_pipe #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .LINK_REG(31)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_rs        (i_rs),
    .i_rt        (i_rt),
    .i_rd        (i_rd),
    .i_c_regdst  (i_c_regdst),
    .i_c_regwrite(i_c_regwrite),
    .i_c_memread (i_c_memread),
    .i_flush     (i_flush),
    .i_wb_we     (i_wb_we),
    .i_wb_addr   (i_wb_addr),
    .i_wb_data   (i_wb_data),
    .i_mfc0      (i_mfc0),
    .i_cop0_data (i_cop0_data),
    .o_valid     (o_valid),
    .o_op1       (o_op1),
    .o_op2       (o_op2),
    .o_wraddr    (o_wraddr),
    .o_regwrite  (o_regwrite),
    .o_memread   (o_memread),
    .o_stall     (o_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic dec(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [1:0] regdst,
                     input logic rw, input logic mr);
    i_valid      = v;
    i_rs         = rs;
    i_rt         = rt;
    i_rd         = rd;
    i_c_regdst   = regdst;
    i_c_regwrite = rw;
    i_c_memread  = mr;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data,
                    input logic mfc0, input logic [31:0] cop0);
    i_wb_we     = we;
    i_wb_addr   = addr;
    i_wb_data   = data;
    i_mfc0      = mfc0;
    i_cop0_data = cop0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_op1"}, o_op1, 32'd0);
    chk({tag, "_op2"}, o_op2, 32'd0);
    chk({tag, "_wraddr"}, 32'(o_wraddr), 32'd0);
    chk({tag, "_regwrite"}, 32'(o_regwrite), 32'd0);
    chk({tag, "_memread"}, 32'(o_memread), 32'd0);
    chk({tag, "_stall"}, 32'(o_stall), 32'd0);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_flush = 1'b0;
    dec(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    wb(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    #2;
    chk_all_zero("reset");
    #6 i_rst_n = 1'b1;

    // Write r5, then read it back through the pipeline.
    wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    dec(1'b1, 5'd5, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0);
    tick();
    chk("r5_op1", o_op1, 32'hDEADBEEF);
    chk("r5_op2", o_op2, 32'd0);
    chk("r5_valid", 32'(o_valid), 32'd1);
    chk("r5_regwrite", 32'(o_regwrite), 32'd1);

    // Same-cycle write-back bypass on rs; rd destination.
    wb(1'b1, 5'd7, 32'h0000_1234, 1'b0, 32'd0);
    dec(1'b1, 5'd7, 5'd5, 5'd12, 2'd1, 1'b1, 1'b0);
    tick();
    chk("bypass_op1", o_op1, 32'h0000_1234);
    chk("bypass_op2", o_op2, 32'hDEADBEEF);
    chk("rd_wraddr", 32'(o_wraddr), 32'd12);

    // Load to r3 followed by a dependent use.
    wb(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    dec(1'b1, 5'd0, 5'd3, 5'd0, 2'd0, 1'b1, 1'b1);
    #1 chk("load_nostall", 32'(o_stall), 32'd0);
    tick();
    chk("load_wraddr", 32'(o_wraddr), 32'd3);
    chk("load_memread", 32'(o_memread), 32'd1);
    dec(1'b1, 5'd3, 5'd0, 5'd4, 2'd1, 1'b1, 1'b0);
    #1 chk("use_stall", 32'(o_stall), 32'd1);
    tick();
    chk("bubble_valid", 32'(o_valid), 32'd0);
    chk("bubble_regwrite", 32'(o_regwrite), 32'd0);
    chk("bubble_memread", 32'(o_memread), 32'd0);
    chk("bubble_stall", 32'(o_stall), 32'd0);
    tick();
    chk("dep_valid", 32'(o_valid), 32'd1);
    chk("dep_wraddr", 32'(o_wraddr), 32'd4);
    chk("dep_stall", 32'(o_stall), 32'd0);

    // Load to r0 never stalls.
    dec(1'b1, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b1);
    tick();
    chk("ld0_memread", 32'(o_memread), 32'd1);
    dec(1'b1, 5'd0, 5'd0, 5'd6, 2'd1, 1'b1, 1'b0);
    #1 chk("ld0_nostall", 32'(o_stall), 32'd0);
    tick();
    chk("ld0_dep_valid", 32'(o_valid), 32'd1);
    chk("ld0_dep_wraddr", 32'(o_wraddr), 32'd6);

    // COP0 write-back into r9; writes to r0 are dropped even with bypass.
    dec(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    wb(1'b1, 5'd9, 32'd0, 1'b1, 32'hA5A5A5A5);
    tick();
    wb(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'd0);
    dec(1'b1, 5'd9, 5'd0, 5'd0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("mfc0_op1", o_op1, 32'hA5A5A5A5);
    chk("r0_bypass_op2", o_op2, 32'd0);
    wb(1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
    dec(1'b1, 5'd0, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("r0_read_op1", o_op1, 32'd0);
    chk("r9_read_op2", o_op2, 32'hA5A5A5A5);

    // Link destination; flush beats a pending stall.
    dec(1'b1, 5'd0, 5'd0, 5'd0, 2'd2, 1'b1, 1'b1);
    tick();
    chk("link_wraddr", 32'(o_wraddr), 32'd31);
    dec(1'b1, 5'd31, 5'd0, 5'd2, 2'd1, 1'b1, 1'b0);
    #1 chk("link_stall", 32'(o_stall), 32'd1);
    i_flush = 1'b1;
    #1 chk("flush_stall", 32'(o_stall), 32'd0);
    tick();
    chk("flush_valid", 32'(o_valid), 32'd0);
    chk("flush_regwrite", 32'(o_regwrite), 32'd0);
    chk("flush_memread", 32'(o_memread), 32'd0);
    i_flush = 1'b0;
    dec(1'b1, 5'd0, 5'd6, 5'd8, 2'd3, 1'b1, 1'b0);
    tick();
    chk("regdst3_wraddr", 32'(o_wraddr), 32'd6);
    chk("regdst3_valid", 32'(o_valid), 32'd1);

    // Reset in the middle of a stall, then confirm r5 was cleared.
    dec(1'b1, 5'd5, 5'd5, 5'd0, 2'd0, 1'b1, 1'b1);
    tick();
    chk("pre_rst_op1", o_op1, 32'hDEADBEEF);
    dec(1'b1, 5'd5, 5'd0, 5'd1, 2'd1, 1'b1, 1'b0);
    #1 chk("pre_rst_stall", 32'(o_stall), 32'd1);
    #1 i_rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    dec(1'b1, 5'd5, 5'd9, 5'd0, 2'd0, 1'b0, 1'b0);
    tick();
    chk("post_rst_valid", 32'(o_valid), 32'd1);
    chk("post_rst_r5", o_op1, 32'd0);
    chk("post_rst_r9", o_op2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
